// File: rtl/vga_fb_timing.sv
// VGA scan engine: programmable sync timing from a system-clock pixel enable,
// with an integrated simple dual-port framebuffer and integer downscaling.
module vga_fb_timing #(
  parameter int unsigned CLK_DIV         = 4,
  parameter int unsigned H_VISIBLE       = 640,
  parameter int unsigned H_FRONT         = 16,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BACK          = 48,
  parameter int unsigned V_VISIBLE       = 480,
  parameter int unsigned V_FRONT         = 10,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BACK          = 33,
  parameter bit          HSYNC_POL       = 1'b0,
  parameter bit          VSYNC_POL       = 1'b0,
  parameter int unsigned VGA_COLOR_DEPTH = 4,
  parameter int unsigned SCALE_SHIFT     = 1,
  localparam int unsigned FB_W     = H_VISIBLE >> SCALE_SHIFT,
  localparam int unsigned FB_H     = V_VISIBLE >> SCALE_SHIFT,
  localparam int unsigned FB_DEPTH = FB_W * FB_H,
  localparam int unsigned ADDR_W   = $clog2(FB_DEPTH),
  localparam int unsigned DATA_W   = 3 * VGA_COLOR_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_i,
  input  logic [ADDR_W-1:0]          wr_addr_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  output logic [VGA_COLOR_DEPTH-1:0] vga_r,
  output logic [VGA_COLOR_DEPTH-1:0] vga_g,
  output logic [VGA_COLOR_DEPTH-1:0] vga_b,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       vga_visible,
  output logic                       frame_start_o
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HC_W     = $clog2(H_TOTAL);
  localparam int unsigned VC_W     = $clog2(V_TOTAL);
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned CD       = VGA_COLOR_DEPTH;

  logic [DIV_W-1:0]  r_div;
  logic [HC_W-1:0]   r_h_cnt;
  logic [VC_W-1:0]   r_v_cnt;
  logic              r_vis1;
  logic              r_hsync;
  logic              r_vsync;
  logic              r_frame_start;
  logic [DATA_W-1:0] r_rd_q;
  logic [DATA_W-1:0] r_mem [FB_DEPTH];

  logic              w_pix_ce;
  logic              w_h_last;
  logic              w_v_last;
  logic              w_vis0;
  logic              w_hs0;
  logic              w_vs0;
  logic              w_wr_ok;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_pix_ce = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_h_last = (r_h_cnt == HC_W'(H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == VC_W'(V_TOTAL - 1));

  assign w_vis0 = (32'(r_h_cnt) < H_VISIBLE) && (32'(r_v_cnt) < V_VISIBLE);
  assign w_hs0  = (32'(r_h_cnt) >= HS_START) && (32'(r_h_cnt) < HS_END);
  assign w_vs0  = (32'(r_v_cnt) >= VS_START) && (32'(r_v_cnt) < VS_END);

  // Address is forced to 0 in blanking so the read never leaves the array.
  assign w_rd_addr = w_vis0
    ? ADDR_W'((32'(r_v_cnt) >> SCALE_SHIFT) * FB_W + (32'(r_h_cnt) >> SCALE_SHIFT))
    : '0;

  assign w_wr_ok = wr_en_i && (32'(wr_addr_i) < FB_DEPTH);

  // Pixel-enable divider: pix_ce on the last count of each pixel period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_pix_ce) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Horizontal / vertical scan counters, advancing once per pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_pix_ce) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + VC_W'(1);
      end else begin
        r_h_cnt <= r_h_cnt + HC_W'(1);
      end
    end
  end

  // Stage-1 control: visibility and sync pins, aligned with the RAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vis1  <= 1'b0;
      r_hsync <= ~HSYNC_POL;
      r_vsync <= ~VSYNC_POL;
    end else if (w_pix_ce) begin
      r_vis1  <= w_vis0;
      r_hsync <= w_hs0 ? HSYNC_POL : ~HSYNC_POL;
      r_vsync <= w_vs0 ? VSYNC_POL : ~VSYNC_POL;
    end
  end

  // Frame pulse: one clk after the counters wrap from the last pixel to (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_pix_ce && w_h_last && w_v_last;
    end
  end

  // Framebuffer write port; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Framebuffer read port (read-first on a same-address collision).
  always_ff @(posedge clk) begin
    if (w_pix_ce) begin
      r_rd_q <= r_mem[w_rd_addr];
    end
  end

  assign vga_r         = r_vis1 ? r_rd_q[DATA_W-1 -: CD] : '0;
  assign vga_g         = r_vis1 ? r_rd_q[2*CD-1 -: CD]   : '0;
  assign vga_b         = r_vis1 ? r_rd_q[CD-1:0]         : '0;
  assign hsync         = r_hsync;
  assign vsync         = r_vsync;
  assign vga_visible   = r_vis1;
  assign frame_start_o = r_frame_start;

endmodule
